ro_assoc_cache: RTL and testbench

//  Small read-only, fully-associative word cache (instruction cache) for the ReVive CPU.
//  - Lookups are keyed by word address; each lookup gives a same-cycle hit flag and the
//    hit data one cycle later.
//  - The fetch path fills the cache with words returned from the AHB bus.
//  - The CPU registers rvalid itself, so its copy lines up with the registered rdata.

---
 rtl/ro_assoc_cache_pkg.sv | 7 +
 rtl/ro_assoc_cache_prio_enc_lsb.sv | 30 +++
 rtl/ro_assoc_cache.sv | 125 ++++++++++++
 tb/tb_ro_assoc_cache.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_assoc_cache_pkg.sv
// Shared constants for the read-only fully-associative word cache.
package ro_assoc_cache_pkg;

    // Byte-offset bits dropped from an address to form the word tag.
    localparam int unsigned OFFSET_BITS = 2;

endpackage

// File: rtl/ro_assoc_cache_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: one-hot of the first request plus its index.
module prio_enc_lsb #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ro_assoc_cache.sv
// Read-only fully-associative word cache: same-cycle hit flag, registered hit data,
// fills go to a matching tag, then the lowest free entry, then a round-robin victim.
module ro_assoc_cache
    import ro_assoc_cache_pkg::*;
#(
    parameter int unsigned W_DATA    = 32,
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned N_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] raddr,
    output logic              rvalid,
    output logic [W_DATA-1:0] rdata,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    input  logic              wen
);

    localparam int unsigned TAG_W = W_ADDR - OFFSET_BITS;
    localparam int unsigned IDX_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [N_ENTRIES];
    logic [W_DATA-1:0]    data_q [N_ENTRIES];
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic [W_DATA-1:0]    rdata_q;

    logic [TAG_W-1:0]     rtag, wtag;
    logic [N_ENTRIES-1:0] hit_vec, wmatch_vec;
    logic [N_ENTRIES-1:0] hit_oh, free_oh, victim_oh, wr_sel;
    logic [IDX_W-1:0]     hit_idx, free_idx;
    logic                 hit_any, free_any, wmatch_any;
    logic [W_DATA-1:0]    hit_data;

    assign rtag = raddr[W_ADDR-1:OFFSET_BITS];
    assign wtag = waddr[W_ADDR-1:OFFSET_BITS];

    always_comb begin
        hit_vec    = '0;
        wmatch_vec = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            hit_vec[i]    = valid_q[i] && (tag_q[i] == rtag);
            wmatch_vec[i] = valid_q[i] && (tag_q[i] == wtag);
        end
    end

    assign wmatch_any = |wmatch_vec;

    prio_enc_lsb #(
        .N (N_ENTRIES)
    ) u_hit_enc (
        .req    (hit_vec),
        .onehot (hit_oh),
        .idx    (hit_idx),
        .any    (hit_any)
    );

    prio_enc_lsb #(
        .N (N_ENTRIES)
    ) u_free_enc (
        .req    (~valid_q),
        .onehot (free_oh),
        .idx    (free_idx),
        .any    (free_any)
    );

    // Indices are redundant here: the one-hot vectors drive the muxes directly.
    logic unused_idx;
    assign unused_idx = ^{hit_idx, free_idx};

    assign rvalid = hit_any;

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (hit_oh[i]) begin
                hit_data = hit_data | data_q[i];
            end
        end
    end

    assign victim_oh = N_ENTRIES'(1) << victim_q;

    always_comb begin
        wr_sel   = '0;
        victim_d = victim_q;
        if (wen) begin
            if (wmatch_any) begin
                wr_sel = wmatch_vec;
            end else if (free_any) begin
                wr_sel = free_oh;
            end else begin
                wr_sel   = victim_oh;
                // Power-of-two depth: natural overflow gives the wrap to 0.
                victim_d = victim_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            victim_q <= '0;
            rdata_q  <= '0;
        end else begin
            valid_q  <= valid_q | wr_sel;
            victim_q <= victim_d;
            rdata_q  <= rvalid ? hit_data : '0;
        end
    end

    // Tags and data are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (wr_sel[i]) begin
                tag_q[i]  <= wtag;
                data_q[i] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_ro_assoc_cache.sv
// Self-checking bench for ro_assoc_cache: directed table, random vs. model, async reset.
module tb_ro_assoc_cache;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] raddr = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic        wen = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ro_assoc_cache #(
        .W_DATA    (32),
        .W_ADDR    (32),
        .N_ENTRIES (N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr  (raddr),
        .rvalid (rvalid),
        .rdata  (rdata),
        .waddr  (waddr),
        .wdata  (wdata),
        .wen    (wen)
    );

    // Reference model: a set of (word address -> data) lines plus a round-robin pointer.
    bit          m_valid [N];
    logic [29:0] m_word  [N];
    logic [31:0] m_data  [N];
    int          m_victim;

    function automatic void m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_victim = 0;
    endfunction

    task automatic m_lookup(input logic [31:0] a, output bit h, output logic [31:0] d);
        h = 0;
        d = '0;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_word[i] == a[31:2]) begin
                h = 1;
                d = m_data[i];
            end
    endtask

    task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
        int slot;
        slot = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_word[i] == a[31:2]) slot = i;
        if (slot < 0)
            for (int i = N - 1; i >= 0; i--)
                if (!m_valid[i]) slot = i;
        if (slot < 0) begin
            slot     = m_victim;
            m_victim = (m_victim + 1) % N;
        end
        m_valid[slot] = 1;
        m_word[slot]  = a[31:2];
        m_data[slot]  = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wen   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
    endtask

    // One cycle: drive at negedge, sample rvalid before the edge, rdata just after it.
    task automatic run_cycle(input logic [31:0] ra, input logic we, input logic [31:0] wa,
                             input logic [31:0] wd, output logic got_v,
                             output logic [31:0] got_d);
        @(negedge clk);
        raddr = ra;
        wen   = we;
        waddr = wa;
        wdata = wd;
        #1 got_v = rvalid;
        @(posedge clk);
        #1 got_d = rdata;
        wen = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] raddr;
        logic        wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.raddr = ra; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.exp_v = ev; v.exp_d = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic        gv;
        logic [31:0] gd;
        bit          mh;
        logic [31:0] md;
        string       nm;

        // Reset, empty lookup, first fill and hit on a different byte offset.
        add(1, 32'h100, 0, 0, 0, 0, 0);
        add(0, 32'h100, 1, 32'h100, 32'hDEADBEEF, 0, 0);
        add(0, 32'h102, 0, 0, 0, 1, 32'hDEADBEEF);
        // Fill 8 words into a clean cache, then overflow into round-robin eviction.
        for (int i = 0; i < 8; i++) begin
            if (i == 0) add(1, 32'h300, 1, 32'h000, 32'h1, 0, 0);
            else        add(0, 32'h300, 1, 32'(4 * i), 32'(4 * i + 1), 0, 0);
        end
        add(0, 32'h01C, 1, 32'h020, 32'h21, 1, 32'h1D);
        add(0, 32'h000, 0, 0, 0, 0, 0);
        add(0, 32'h020, 0, 0, 0, 1, 32'h21);
        // Evict entry1 while it is being read: the old data is still returned.
        add(0, 32'h004, 1, 32'h024, 32'h25, 1, 32'h5);
        add(0, 32'h004, 0, 0, 0, 0, 0);
        add(0, 32'h024, 0, 0, 0, 1, 32'h25);
        // In-place refill of 0x008 leaves the victim pointer on entry2.
        add(0, 32'h008, 1, 32'h008, 32'h55AA55AA, 1, 32'h9);
        add(0, 32'h008, 0, 0, 0, 1, 32'h55AA55AA);
        add(0, 32'h300, 1, 32'h028, 32'h29, 0, 0);
        add(0, 32'h008, 0, 0, 0, 0, 0);
        add(0, 32'h00C, 0, 0, 0, 1, 32'hD);
        add(0, 32'h028, 0, 0, 0, 1, 32'h29);
        // Same-cycle fill and lookup of a new tag: no bypass.
        add(0, 32'h200, 1, 32'h200, 32'h2222, 0, 0);
        add(0, 32'h200, 0, 0, 0, 1, 32'h2222);
        add(0, 32'h00C, 0, 0, 0, 0, 0);
        // Lowest free entry is reused after reset with partial fills.
        add(1, 32'h040, 1, 32'h040, 32'hA, 0, 0);
        add(0, 32'h040, 1, 32'h044, 32'hB, 1, 32'hA);
        add(0, 32'h044, 0, 0, 0, 1, 32'hB);

        #1;
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            run_cycle(vecs[k].raddr, vecs[k].wen, vecs[k].waddr, vecs[k].wdata, gv, gd);
            nm = $sformatf("vec%0d_rvalid", k);
            check(nm, {31'b0, gv}, {31'b0, vecs[k].exp_v});
            nm = $sformatf("vec%0d_rdata", k);
            check(nm, gd, vecs[k].exp_d);
        end

        // Random traffic over 12 words so the cache keeps evicting.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ra, wa, wd;
            logic        we;
            ra = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
            wa = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
            wd = $urandom;
            we = ($urandom_range(0, 2) == 0);
            m_lookup(ra, mh, md);
            run_cycle(ra, we, wa, wd, gv, gd);
            check("rand_rvalid", {31'b0, gv}, {31'b0, mh});
            check("rand_rdata", gd, mh ? md : 32'h0);
            if (we) m_fill(wa, wd);
        end

        // Asynchronous reset while a fill is pending and rdata holds a hit.
        run_cycle(32'h300, 1, 32'h3F0, 32'hA5A5A5A5, gv, gd);
        run_cycle(32'h3F0, 1, 32'h3F4, 32'h12345678, gv, gd);
        check("pre_reset_rdata", gd, 32'hA5A5A5A5);
        @(negedge clk);
        raddr = 32'h3F0;
        wen   = 1'b1;
        waddr = 32'h3F8;
        wdata = 32'h77;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdata", rdata, 32'h0);
        check("async_rvalid", {31'b0, rvalid}, 32'h0);
        @(negedge clk);
        wen   = 1'b0;
        rst_n = 1'b1;
        m_clear();
        for (int i = 0; i < 16; i++) begin
            run_cycle(32'h3E0 + 32'(4 * (i % 8)) + ((i < 8) ? 32'h0 : 32'h0), 0, 0, 0, gv, gd);
            check("post_reset_rvalid", {31'b0, gv}, 32'h0);
            run_cycle(32'(4 * i), 0, 0, 0, gv, gd);
            check("post_reset_low_rvalid", {31'b0, gv}, 32'h0);
        end
        check("post_reset_rdata", gd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
